fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the decode unit. It holds the PC, reads instruction memory, predicts taken branches and jumps with a small direct-mapped BTB using 2-bit counters, and drives the IF/ID pipeline register that decode consumes. Execute-stage redirects and hazard-unit stall/flush requests act on this block.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- NOP_INSTR, 32'h0000_0013, bubble written into IF/ID (addi x0,x0,0)
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace IF/ID contents with a bubble
- redirect_valid  in  1  execute resolved a misprediction
- redirect_pc  in  32  correct next PC
- update_valid  in  1  resolved branch/jump, BTB training
- update_pc  in  32  PC of the resolved instruction
- update_target  in  32  resolved target
- update_taken  in  1  resolved direction
- imem_addr  out  32  instruction address; equals PC register
- imem_rdata  in  32  instruction word; combinational read of imem_addr
- if_pc  out  32  IF/ID PC
- if_instr  out  32  IF/ID instruction
- if_pred_taken  out  1  IF/ID prediction bit
- if_valid  out  1  IF/ID entry is a real instruction

## Operation
- BTB entry: valid, tag = pc[31:IDX+2], target[31:0], state[1:0]. Index = pc[IDX+1:2].
- State codes: STRONG_NOT_TAKEN 2'b00, WEAK_NOT_TAKEN 2'b01, STRONG_TAKEN 2'b10, WEAK_TAKEN 2'b11. Predict taken iff valid, tag match, and state[1]=1.
- Taken transitions: SNT→WNT→WT→ST; ST stays. Not-taken transitions: ST→WT→WNT→SNT; SNT stays.
- Update on hit: apply the transition. On taken, also write update_target.
- Update on miss: if taken, allocate the entry with valid=1, the tag, update_target, and WEAK_TAKEN. If not taken, make no change.
- Next-PC priority, highest first: rst→RESET_PC; redirect_valid→redirect_pc; stall→hold; predicted taken→BTB target; else PC+4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
- IF/ID priority, highest first:
  - rst → {pc=RESET_PC, instr=NOP_INSTR, pred=0, valid=0}.
  - flush or redirect_valid → bubble with the same values; this overrides stall.
  - stall → hold.
  - Otherwise capture {PC, imem_rdata, prediction, 1}.
- Lookup and update collide on the same index in the same cycle: the lookup uses the pre-update entry, and the update is visible from the next cycle.
- Reset clears every BTB valid bit in the same edge. Target and state contents are don't-care.

## Timing
- Reset values: imem_addr=RESET_PC, if_pc=RESET_PC, if_instr=NOP_INSTR, if_pred_taken=0, if_valid=0, all BTB valid bits=0.
- Fetch latency is one cycle. The word at address A appears on if_instr at the edge after imem_addr=A, provided there is no stall or flush.
- Prediction adds zero penalty: the target is fetched in the cycle following the predicted instruction.
- Redirect at edge N: PC←redirect_pc and IF/ID←bubble. At edge N+1, IF/ID holds the redirected instruction with if_valid=1.
- Stall is a level signal. The PC and IF/ID hold for every cycle it is high, and the BTB still accepts updates.
- Reset asserted mid-operation takes effect at the next edge. Redirect, update and stall are ignored in that cycle.

## Structure
- The shared defines header holds the BTB state codes, NOP_INSTR and the default RESET_PC.
- One sub-module, `branch_target_buffer`:
  - Ports: lookup_pc, hit_taken, hit_target, and the update port.
  - Storage is flop arrays with a synchronous clear on rst.
- The top level contains the PC register, next-PC mux and IF/ID register.

## Test plan
- Reset, then free run over imem holding 32'h0000_0013 everywhere → imem_addr goes 0,4,8,… and if_valid rises one cycle after reset is released.
- Stall for 3 cycles at PC=0x10 → imem_addr stays 0x10 and IF/ID holds its contents. After release, the fetch sequence resumes at 0x14.
- Redirect to 0x200 while stall=1 → next PC is 0x200 and IF/ID becomes a bubble. One cycle later if_pc=0x200 and if_valid=1.
- Update pc=0x40, target=0x80, taken once → next fetch of 0x40 predicts taken, and the fetch after it is 0x80. Two not-taken updates then send the entry WT→WNT→SNT, and 0x40 is followed by 0x44.
- Not-taken update on a miss → no allocation and no prediction. An update at the same index as the current lookup in the same cycle → the current prediction uses the old state.
- Reset asserted mid-run with trained entries → all predictions cleared, PC=RESET_PC, if_valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: BTB counter codes, bubble
// instruction, default reset PC and the 2-bit counter transition helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } btb_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  function automatic btb_state_e btb_next_state(input btb_state_e s, input logic taken);
    btb_state_e n;
    n = s;
    case (s)
      STRONG_NOT_TAKEN: n = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   n = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       n = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     n = taken ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; combinational
// lookup against the registered entries, training on the clock edge.
module branch_target_buffer
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        hit_taken,
  output logic [31:0] hit_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  btb_state_e         r_state  [ENTRIES];

  logic [IDX-1:0]  w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic [IDX-1:0]  w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic            w_up_hit;
  logic            w_unused_lsbs;

  assign w_lk_idx      = lookup_pc[IDX+1:2];
  assign w_lk_tag      = lookup_pc[31:IDX+2];
  assign w_up_idx      = update_pc[IDX+1:2];
  assign w_up_tag      = update_pc[31:IDX+2];
  assign w_unused_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads the registered entry, so a same-cycle update is not seen.
  assign hit_taken  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && r_state[w_lk_idx][1];
  assign hit_target = r_target[w_lk_idx];

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (update_valid) begin
      if (w_up_hit) begin
        r_state[w_up_idx] <= btb_next_state(r_state[w_up_idx], update_taken);
        if (update_taken) r_target[w_up_idx] <= update_target;
      end else if (update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_state[w_up_idx]  <= WEAK_TAKEN;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, BTB-driven next-PC selection
// and the IF/ID pipeline register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_pred_taken,
  output logic        if_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_pred;
  logic        r_if_valid;

  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  logic [31:0] w_next_pc;

  branch_target_buffer #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (r_pc),
    .hit_taken    (w_pred_taken),
    .hit_target   (w_pred_target),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_taken (update_taken)
  );

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (redirect_valid)    w_next_pc = redirect_pc;
    else if (stall)        w_next_pc = r_pc;
    else if (w_pred_taken) w_next_pc = w_pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  // A redirect squashes the in-flight fetch even while decode is stalled.
  always_ff @(posedge clk) begin
    if (rst || flush || redirect_valid) begin
      r_if_pc    <= RESET_PC;
      r_if_instr <= NOP_INSTR;
      r_if_pred  <= 1'b0;
      r_if_valid <= 1'b0;
    end else if (!stall) begin
      r_if_pc    <= r_pc;
      r_if_instr <= imem_rdata;
      r_if_pred  <= w_pred_taken;
      r_if_valid <= 1'b1;
    end
  end

  assign imem_addr     = r_pc;
  assign if_pc         = r_if_pc;
  assign if_instr      = r_if_instr;
  assign if_pred_taken = r_if_pred;
  assign if_valid      = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a cycle-level
// behavioural model (counter held as 0..3 confidence, predict when >= 2).
module tb_fetch_stage;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX     = $clog2(ENTRIES);
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        update_valid = 1'b0, update_taken = 1'b0;
  logic [31:0] update_pc = '0, update_target = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_instr;
  logic        if_pred_taken, if_valid;

  int unsigned mode = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // model state
  logic [31:0] m_pc, m_if_pc, m_if_instr;
  logic        m_if_pred, m_if_valid;
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .BTB_ENTRIES(ENTRIES),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a, input int unsigned md);
    return (md == 0) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'hC0DE_0000);
  endfunction

  always_comb imem_rdata = imem_word(imem_addr, mode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic r);
    int unsigned li, ui;
    logic pred;
    logic [31:0] nxt;
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = ut; rst = r;

    li   = (m_pc >> 2) % ENTRIES;
    pred = m_valid[li] && (m_tag[li] == (m_pc >> (IDX + 2))) && (m_cnt[li] >= 2);
    if (r) begin
      m_pc = RST_PC; m_if_pc = RST_PC; m_if_instr = NOP; m_if_pred = 0; m_if_valid = 0;
      foreach (m_valid[k]) m_valid[k] = 0;
    end else begin
      if (f || rv) begin
        m_if_pc = RST_PC; m_if_instr = NOP; m_if_pred = 0; m_if_valid = 0;
      end else if (!s) begin
        m_if_pc = m_pc; m_if_instr = imem_word(m_pc, mode); m_if_pred = pred; m_if_valid = 1;
      end
      if (rv)        nxt = rpc;
      else if (s)    nxt = m_pc;
      else if (pred) nxt = m_tgt[li];
      else           nxt = m_pc + 32'd4;
      m_pc = nxt;
      if (uv) begin
        ui = (upc >> 2) % ENTRIES;
        if (m_valid[ui] && m_tag[ui] == (upc >> (IDX + 2))) begin
          if (ut) begin
            m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
            m_tgt[ui] = utgt;
          end else begin
            m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = upc >> (IDX + 2); m_tgt[ui] = utgt; m_cnt[ui] = 2;
        end
      end
    end

    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("if_pc", if_pc, m_if_pc);
    check("if_instr", if_instr, m_if_instr);
    check("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, m_if_pred});
    check("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] pc);
    step(0, 0, 1, pc, 0, '0, '0, 0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    step(0, 0, 0, '0, 1, pc, tgt, tk, 0);
  endtask

  initial begin
    m_pc = RST_PC; m_if_pc = RST_PC; m_if_instr = NOP; m_if_pred = 0; m_if_valid = 0;
    foreach (m_valid[k]) begin m_valid[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_cnt[k] = 0; end

    // reset, then free run over a NOP-filled memory
    step(0, 0, 0, '0, 0, '0, '0, 0, 1);
    step(1, 1, 1, 32'h100, 1, 32'h8, 32'h20, 1, 1);
    idle(4);
    check("pc_at_0x10", imem_addr, 32'h10);
    // three-cycle stall at 0x10, then resume at 0x14
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0, '0, 0, 0);
    idle(2);
    // redirect overrides stall
    step(1, 0, 1, 32'h200, 0, '0, '0, 0, 0);
    idle(2);

    mode = 1;
    train(32'h40, 32'h80, 1);
    redir(32'h40);
    idle(3);
    train(32'h40, 32'h80, 0);
    train(32'h40, 32'h80, 0);
    redir(32'h40);
    idle(2);
    // not-taken miss allocates nothing
    train(32'h300, 32'h500, 0);
    redir(32'h300);
    idle(2);
    // same-index update while 0x40 is being looked up
    train(32'h40, 32'h80, 1);
    train(32'h40, 32'h80, 1);
    redir(32'h40);
    step(0, 0, 0, '0, 1, 32'h40, 32'h80, 0, 0);
    idle(1);
    // address wrap
    redir(32'hFFFF_FFF8);
    idle(3);
    step(0, 1, 0, '0, 0, '0, '0, 0, 0);
    step(1, 1, 0, '0, 0, '0, '0, 0, 0);
    idle(1);
    // reset with trained entries present
    train(32'h40, 32'h80, 1);
    redir(32'h40);
    idle(1);
    step(0, 0, 1, 32'h40, 1, 32'h40, 32'h80, 1, 1);
    redir(32'h40);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic s, f, rv, uv, ut, r;
      logic [31:0] rpc, upc, utgt;
      s    = ($urandom_range(0, 7) == 0);
      f    = ($urandom_range(0, 9) == 0);
      rv   = ($urandom_range(0, 5) == 0);
      uv   = ($urandom_range(0, 2) == 0);
      ut   = $urandom_range(0, 1) == 1;
      r    = ($urandom_range(0, 99) == 0);
      rpc  = {20'b0, $urandom_range(0, 255) * 4};
      upc  = {20'b0, $urandom_range(0, 255) * 4};
      utgt = {20'b0, $urandom_range(0, 255) * 4};
      step(s, f, rv, rpc, uv, upc, utgt, ut, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
